// File: rtl/lsu_issue_queue_if.sv
// Dispatch-side and execute-side signal bundle for lsu_issue_queue.
// The master modport is the producer side (dispatch, writeback, branch unit).
interface lsu_issue_queue_if #(
  parameter int unsigned DEPTH_LOG = 3,
  parameter int unsigned WIDTH_BRM = 4,
  parameter int unsigned WIDTH_REG = 5,
  parameter int unsigned WIDTH     = 1 + 7 + WIDTH_BRM + WIDTH_REG + 10 + 4 * 32
);
  logic                   en_val;
  logic                   en_ready;
  logic [6:0]             en_uop;
  logic [WIDTH_BRM-1:0]   en_brmask;
  logic [WIDTH_REG-1:0]   en_rd;
  logic [31:0]            en_pc;
  logic [9:0]             en_func;
  logic [31:0]            en_imm;
  logic [WIDTH_REG-1:0]   en_rs1;
  logic [WIDTH_REG-1:0]   en_rs2;
  logic                   en_rdy1;
  logic                   en_rdy2;
  logic [31:0]            en_op1;
  logic [31:0]            en_op2;
  logic [WIDTH_REG+32:0]  bypass;
  logic                   br_kill;
  logic                   br_clear;
  logic [WIDTH_BRM-1:0]   br_mask;
  logic [WIDTH-1:0]       instr;
  logic [DEPTH_LOG:0]     count;

  modport master (
    output en_val, en_uop, en_brmask, en_rd, en_pc, en_func, en_imm,
    output en_rs1, en_rs2, en_rdy1, en_rdy2, en_op1, en_op2,
    output bypass, br_kill, br_clear, br_mask,
    input  en_ready, instr, count
  );

  modport slave (
    input  en_val, en_uop, en_brmask, en_rd, en_pc, en_func, en_imm,
    input  en_rs1, en_rs2, en_rdy1, en_rdy2, en_op1, en_op2,
    input  bypass, br_kill, br_clear, br_mask,
    output en_ready, instr, count
  );
endinterface

// File: rtl/lsu_issue_queue.sv
// In-order load/store issue queue with bypass wakeup and branch kill/clear.
// Define LSQ_BYPASS_EN to let the head issue in the same cycle its operand is broadcast.
module lsu_issue_queue #(
  parameter int unsigned DEPTH_LOG = 3,
  parameter int unsigned WIDTH_BRM = 4,
  parameter int unsigned WIDTH_REG = 5,
  parameter int unsigned WIDTH     = 1 + 7 + WIDTH_BRM + WIDTH_REG + 10 + 4 * 32
) (
  input logic             clk,
  input logic             rst,
  lsu_issue_queue_if.slave q
);
  localparam int unsigned Depth    = 2 ** DEPTH_LOG;
  localparam logic [6:0]  UopLoad  = 7'b0000011;
  localparam logic [6:0]  UopStore = 7'b0100011;

  typedef logic [DEPTH_LOG-1:0] ptr_t;

  logic                 bp_val;
  logic [WIDTH_REG-1:0] bp_tag;
  logic [31:0]          bp_data;
  logic                 clear;

  ptr_t               head_q, head_d, tail_q, tail_d;
  logic [DEPTH_LOG:0] count_q, count_d;

  logic [Depth-1:0] val_q, val_d, rdy1_q, rdy1_d, rdy2_q, rdy2_d;
  logic [Depth-1:0] wake1, wake2, killed;
  logic [WIDTH_BRM-1:0] brm_q [Depth];
  logic [WIDTH_BRM-1:0] brm_d [Depth];

  logic [6:0]           uop_q  [Depth];
  logic [WIDTH_REG-1:0] rd_q   [Depth];
  logic [31:0]          pc_q   [Depth];
  logic [9:0]           func_q [Depth];
  logic [31:0]          imm_q  [Depth];
  logic [WIDTH_REG-1:0] rs1_q  [Depth];
  logic [WIDTH_REG-1:0] rs2_q  [Depth];
  logic [31:0]          op1_q  [Depth];
  logic [31:0]          op2_q  [Depth];

  logic                 en_drop, enq, en_rdy1, en_rdy2;
  logic [31:0]          en_op1, en_op2;
  logic [WIDTH_BRM-1:0] en_brm;

  logic        head_val, head_rdy1, head_rdy2, issue, pop;
  logic [31:0] head_op1, head_op2;

  logic                 out_val_q, out_val_d;
  logic [6:0]           out_uop_q, out_uop_d;
  logic [WIDTH_BRM-1:0] out_brm_q, out_brm_d;
  logic [WIDTH_REG-1:0] out_rd_q, out_rd_d;
  logic [31:0]          out_pc_q, out_pc_d;
  logic [9:0]           out_func_q, out_func_d;
  logic [31:0]          out_imm_q, out_imm_d;
  logic [31:0]          out_op1_q, out_op1_d;
  logic [31:0]          out_op2_q, out_op2_d;
  logic [WIDTH-1:0]     instr_w;

  assign {bp_val, bp_tag, bp_data} = q.bypass;
  assign clear = q.br_clear && !q.br_kill;

  assign q.en_ready = (count_q != (DEPTH_LOG + 1)'(Depth));
  assign q.count    = count_q;
  assign instr_w    = {out_val_q, out_uop_q, out_brm_q, out_rd_q, out_pc_q, out_func_q,
                       out_imm_q, out_op2_q, out_op1_q};
  assign q.instr    = instr_w;

  // Incoming op: tag 0 or a same-cycle bypass hit makes the operand ready on entry.
  always_comb begin
    en_drop = q.br_kill && (|(q.en_brmask & q.br_mask));
    enq     = q.en_val && q.en_ready && !en_drop;
    en_rdy1 = q.en_rdy1 || (q.en_rs1 == '0) || (bp_val && (bp_tag == q.en_rs1));
    en_rdy2 = q.en_rdy2 || (q.en_rs2 == '0) || (bp_val && (bp_tag == q.en_rs2));
    en_op1  = (q.en_rdy1 || (q.en_rs1 == '0)) ? q.en_op1 : bp_data;
    en_op2  = (q.en_rdy2 || (q.en_rs2 == '0)) ? q.en_op2 : bp_data;
    en_brm  = clear ? (q.en_brmask & ~q.br_mask) : q.en_brmask;
  end

  always_comb begin
    for (int unsigned i = 0; i < Depth; i++) begin
      killed[i] = q.br_kill && (|(brm_q[i] & q.br_mask));
      wake1[i]  = val_q[i] && !rdy1_q[i] && bp_val && (bp_tag == rs1_q[i]);
      wake2[i]  = val_q[i] && !rdy2_q[i] && bp_val && (bp_tag == rs2_q[i]);
    end
  end

  // Only the head is considered; a killed-but-present head is retired without issue.
  always_comb begin
    head_val  = val_q[head_q] && !killed[head_q];
`ifdef LSQ_BYPASS_EN
    head_rdy1 = rdy1_q[head_q] || wake1[head_q];
    head_rdy2 = rdy2_q[head_q] || wake2[head_q];
    head_op1  = rdy1_q[head_q] ? op1_q[head_q] : bp_data;
    head_op2  = rdy2_q[head_q] ? op2_q[head_q] : bp_data;
`else
    head_rdy1 = rdy1_q[head_q];
    head_rdy2 = rdy2_q[head_q];
    head_op1  = op1_q[head_q];
    head_op2  = op2_q[head_q];
`endif
    case (uop_q[head_q])
      UopLoad:  issue = head_val && head_rdy1;
      UopStore: issue = head_val && head_rdy1 && head_rdy2;
      default:  issue = head_val;
    endcase
    pop = issue || ((count_q != '0) && !val_q[head_q]);
  end

  always_comb begin
    val_d  = val_q;
    rdy1_d = rdy1_q;
    rdy2_d = rdy2_q;
    brm_d  = brm_q;
    head_d = pop ? head_q + 1'b1 : head_q;
    tail_d = enq ? tail_q + 1'b1 : tail_q;
    count_d = count_q;
    if (enq && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!enq && pop) begin
      count_d = count_q - 1'b1;
    end
    for (int unsigned i = 0; i < Depth; i++) begin
      if (killed[i]) val_d[i] = 1'b0;
      if (wake1[i])  rdy1_d[i] = 1'b1;
      if (wake2[i])  rdy2_d[i] = 1'b1;
      if (clear)     brm_d[i] = brm_q[i] & ~q.br_mask;
    end
    if (pop) val_d[head_q] = 1'b0;
    if (enq) begin
      val_d[tail_q]  = 1'b1;
      rdy1_d[tail_q] = en_rdy1;
      rdy2_d[tail_q] = en_rdy2;
      brm_d[tail_q]  = en_brm;
    end
  end

  // A non-issuing cycle drops val but keeps the last word so downstream sees stable fields.
  always_comb begin
    out_val_d  = 1'b0;
    out_uop_d  = out_uop_q;
    out_brm_d  = clear ? (out_brm_q & ~q.br_mask) : out_brm_q;
    out_rd_d   = out_rd_q;
    out_pc_d   = out_pc_q;
    out_func_d = out_func_q;
    out_imm_d  = out_imm_q;
    out_op1_d  = out_op1_q;
    out_op2_d  = out_op2_q;
    if (issue) begin
      out_val_d  = 1'b1;
      out_uop_d  = uop_q[head_q];
      out_brm_d  = clear ? (brm_q[head_q] & ~q.br_mask) : brm_q[head_q];
      out_rd_d   = rd_q[head_q];
      out_pc_d   = pc_q[head_q];
      out_func_d = func_q[head_q];
      out_imm_d  = imm_q[head_q];
      out_op1_d  = head_op1;
      out_op2_d  = head_op2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      val_q      <= '0;
      rdy1_q     <= '0;
      rdy2_q     <= '0;
      for (int unsigned i = 0; i < Depth; i++) brm_q[i] <= '0;
      out_val_q  <= 1'b0;
      out_uop_q  <= '0;
      out_brm_q  <= '0;
      out_rd_q   <= '0;
      out_pc_q   <= '0;
      out_func_q <= '0;
      out_imm_q  <= '0;
      out_op1_q  <= '0;
      out_op2_q  <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      val_q      <= val_d;
      rdy1_q     <= rdy1_d;
      rdy2_q     <= rdy2_d;
      brm_q      <= brm_d;
      out_val_q  <= out_val_d;
      out_uop_q  <= out_uop_d;
      out_brm_q  <= out_brm_d;
      out_rd_q   <= out_rd_d;
      out_pc_q   <= out_pc_d;
      out_func_q <= out_func_d;
      out_imm_q  <= out_imm_d;
      out_op1_q  <= out_op1_d;
      out_op2_q  <= out_op2_d;
    end
  end

  // Payload is qualified by val/rdy, so it needs no reset.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < Depth; i++) begin
      if (wake1[i]) op1_q[i] <= bp_data;
      if (wake2[i]) op2_q[i] <= bp_data;
    end
    if (enq) begin
      uop_q[tail_q]  <= q.en_uop;
      rd_q[tail_q]   <= q.en_rd;
      pc_q[tail_q]   <= q.en_pc;
      func_q[tail_q] <= q.en_func;
      imm_q[tail_q]  <= q.en_imm;
      rs1_q[tail_q]  <= q.en_rs1;
      rs2_q[tail_q]  <= q.en_rs2;
      op1_q[tail_q]  <= en_op1;
      op2_q[tail_q]  <= en_op2;
    end
  end
endmodule
